inst_cache: RTL and testbench

- Direct-mapped, one-word-per-line instruction cache between the CPU instruction-fetch port and a slower external instruction memory with a request/ready handshake.
- Sits directly upstream of the CPU: it drives the CPU's rom_data input and takes rom_chip_enable/rom_address.
- On a hit it returns the instruction combinationally in the same cycle.
- On a miss it raises stall_request, which control consumes as a third stall source, and refills from external memory.

---
 rtl/inst_cache.sv | 122 ++++++++++++
 tb/tb_inst_cache.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache; optional hit/miss counters under INST_CACHE_STATS_EN.
// Latency: hit data is combinational in the fetch cycle; a miss costs at least 2 cycles (request, then fill).
// Backpressure: stall_request freezes the CPU while the single outstanding refill waits on mem_ready.
module inst_cache #(
  parameter int INDEX_WIDTH = 4
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        chip_enable,
  input  logic [31:0] address,
  input  logic        flush,
  output logic [31:0] data,
  output logic        stall_request,
  output logic        mem_request,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_data,
  input  logic        mem_ready
`ifdef INST_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                 state, next_state;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [31:0]            word_mem [LINES];

  logic [INDEX_WIDTH-1:0] idx, fill_idx;
  logic [TAG_WIDTH-1:0]   tag, fill_tag;
  logic                   hit, miss_start, fill_en;
  logic                   unused_addr_lsbs;

  // Lookup uses the live fetch address; the fill uses the latched miss address
  // so the written line is correct even if the CPU address wanders.
  assign idx      = address[INDEX_WIDTH+1:2];
  assign tag      = address[31:INDEX_WIDTH+2];
  assign fill_idx = mem_address[INDEX_WIDTH+1:2];
  assign fill_tag = mem_address[31:INDEX_WIDTH+2];
  assign unused_addr_lsbs = ^address[1:0];

  assign hit  = chip_enable & valid[idx] & (tag_mem[idx] == tag);
  assign data = hit ? word_mem[idx] : 32'h0;

  // Next-state and stall decode: miss detection only in IDLE, WAIT always stalls.
  always_comb begin
    next_state    = state;
    stall_request = 1'b0;
    miss_start    = 1'b0;
    fill_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_request = chip_enable & ~hit;
        if (chip_enable & ~hit) begin
          miss_start = 1'b1;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_request = 1'b1;
        if (mem_ready) begin
          fill_en    = 1'b1;
          next_state = ST_IDLE;
        end
      end
    endcase
  end

  // State register plus the registered external request/address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      mem_request <= 1'b0;
      mem_address <= 32'h0;
    end else begin
      state <= next_state;
      if (miss_start) begin
        mem_request <= 1'b1;
        mem_address <= {address[31:2], 2'b00};
      end else if (fill_en) begin
        mem_request <= 1'b0;
      end
    end
  end

  // Valid bits: flush beats a simultaneous fill, leaving the new line invalid.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/word storage needs no reset; valid gates every use of it.
  always_ff @(posedge clock) begin
    if (fill_en && !reset) begin
      tag_mem[fill_idx]  <= fill_tag;
      word_mem[fill_idx] <= mem_data;
    end
  end

`ifdef INST_CACHE_STATS_EN
  // Hits counted only in IDLE; misses counted on entry to WAIT. Flush leaves them alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (state == ST_IDLE && hit) hit_count <= hit_count + 32'h1;
      if (miss_start)              miss_count <= miss_count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Randomised self-checking bench for inst_cache with directed scenarios first.
// Reference model tracks cached word addresses per line and one pending refill.
// Inputs change 1 ns after posedge; outputs are compared at negedge.
module tb_inst_cache;

  logic        clock = 1'b0;
  logic        reset, chip_enable, flush, mem_ready;
  logic [31:0] address, mem_data;
  logic [31:0] data, mem_address;
  logic        stall_request, mem_request;
`ifdef INST_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  inst_cache #(.INDEX_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .chip_enable(chip_enable), .address(address),
    .flush(flush), .data(data), .stall_request(stall_request),
    .mem_request(mem_request), .mem_address(mem_address),
    .mem_data(mem_data), .mem_ready(mem_ready)
`ifdef INST_CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_seen = 0;

  // Reference model: which word address each of the 16 lines holds.
  bit          m_valid [16];
  logic [29:0] m_line  [16];
  logic [31:0] m_word  [16];
  bit          m_busy;
  logic [31:0] m_maddr;
  logic [31:0] m_hits, m_misses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_busy = 1'b0; m_maddr = 32'h0; m_hits = 32'h0; m_misses = 32'h0;
  endtask

  // One clock cycle: drive, compare at negedge, advance model at posedge.
  task automatic step(input logic ce, input logic [31:0] a, input logic fl,
                      input logic rdy, input logic [31:0] md, input logic rst);
    int  li, fi;
    bit  hit_e;
    chip_enable = ce; address = a; flush = fl; mem_ready = rdy; mem_data = md; reset = rst;
    @(negedge clock);
    li    = int'(a[5:2]);
    hit_e = ce && m_valid[li] && (m_line[li] == a[31:2]);
    check("data",     data,          hit_e ? m_word[li] : 32'h0);
    check("stall",    {31'h0, stall_request}, {31'h0, m_busy || (ce && !hit_e)});
    check("mem_req",  {31'h0, mem_request},   {31'h0, m_busy});
    check("mem_addr", mem_address,   m_maddr);
`ifdef INST_CACHE_STATS_EN
    check("hit_cnt",  hit_count,     m_hits);
    check("miss_cnt", miss_count,    m_misses);
`endif
    if (stall_request) stall_seen++;
    @(posedge clock);
    if (rst) begin
      model_reset();
    end else begin
      if (m_busy) begin
        if (rdy) begin
          fi = int'(m_maddr[5:2]);
          m_line[fi] = m_maddr[31:2]; m_word[fi] = md; m_valid[fi] = 1'b1;
          m_busy = 1'b0;
        end
      end else if (ce) begin
        if (hit_e) m_hits++;
        else begin m_busy = 1'b1; m_maddr = {a[31:2], 2'b00}; m_misses++; end
      end
      if (fl) foreach (m_valid[i]) m_valid[i] = 1'b0;
    end
    #1;
  endtask

  logic [31:0] cur_addr;

  initial begin
    foreach (m_line[i]) begin m_line[i] = '0; m_word[i] = '0; end
    chip_enable = 0; address = 0; flush = 0; mem_ready = 0; mem_data = 0; reset = 1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();

    // Reset state with nothing fetched.
    step(0, 32'h0, 0, 0, 32'h0, 0);
    check("rst_mem_req", {31'h0, mem_request}, 32'h0);
    check("rst_mem_addr", mem_address, 32'h0);

    // Cold miss on 0x0, ready three cycles after the miss.
    stall_seen = 0;
    step(1, 32'h0, 0, 0, 32'h0, 0);
    step(1, 32'h0, 0, 0, 32'h0, 0);
    step(1, 32'h0, 0, 0, 32'h0, 0);
    step(1, 32'h0, 0, 1, 32'h3C010101, 0);
    check("t1_stall_cycles", stall_seen, 4);
    check("t1_data", data, 32'h3C010101);
    check("t1_stall_after", {31'h0, stall_request}, 32'h0);

    // Re-fetch hits with no new request.
    step(1, 32'h0, 0, 0, 32'h0, 0);
    check("t2_mem_req", {31'h0, mem_request}, 32'h0);
`ifdef INST_CACHE_STATS_EN
    check("t2_hits", hit_count, 32'd1);
    check("t2_misses", miss_count, 32'd1);
`endif

    // Conflict on index 1: 0x04 vs 0x44.
    step(1, 32'h4, 0, 0, 32'h0, 0);
    step(1, 32'h4, 0, 1, 32'h1111_0004, 0);
    step(1, 32'h4, 0, 0, 32'h0, 0);
    step(1, 32'h44, 0, 0, 32'h0, 0);
    check("t3_conf_addr", mem_address, 32'h44);
    step(1, 32'h44, 0, 1, 32'h2222_0044, 0);
    step(1, 32'h4, 0, 0, 32'h0, 0);
    check("t3_remiss", {31'h0, mem_request}, 32'h1);
    step(1, 32'h4, 0, 1, 32'h1111_0004, 0);

    // Flush coinciding with the fill for 0x08.
    step(1, 32'h8, 0, 0, 32'h0, 0);
    step(1, 32'h8, 1, 1, 32'h3333_0008, 0);
    check("t4_idle", {31'h0, mem_request}, 32'h0);
    step(1, 32'h8, 0, 0, 32'h0, 0);
    check("t4_remiss", {31'h0, mem_request}, 32'h1);
    step(1, 32'h8, 0, 1, 32'h3333_0008, 0);

    // Reset in WAIT, then a late mem_ready.
    step(1, 32'hC, 0, 0, 32'h0, 0);
    step(1, 32'hC, 0, 0, 32'h0, 1);
    step(0, 32'hC, 0, 1, 32'h4444_000C, 0);
    check("t5_req_dropped", {31'h0, mem_request}, 32'h0);
    step(1, 32'hC, 0, 0, 32'h0, 0);
    check("t5_remiss", {31'h0, mem_request}, 32'h1);
    step(1, 32'hC, 0, 1, 32'h4444_000C, 0);

    // Idle fetch port with mem_ready toggling.
    for (int i = 0; i < 8; i++)
      step(0, $urandom, 0, i[0], $urandom, 0);
    check("t6_mem_req", {31'h0, mem_request}, 32'h0);

    // Random traffic over a small address space to mix hits, conflicts and flushes.
    cur_addr = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if (!m_busy)
        cur_addr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      step($urandom_range(0, 9) < 8, cur_addr, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
